// File: rtl/eth_tx_mq_sched.sv
// Multi-queue frame scheduler: N per-channel byte streams into one MAC TX stream.
// Optional per-frame length cap enabled by defining ETH_TX_MQ_LEN_LIMIT_EN.
module eth_tx_mq_sched #(
    parameter int    CHANNELS      = 4,
    parameter string ARB_MODE      = "RR",
    parameter int    MAX_FRAME_LEN = 1518,
    parameter int    CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  tx_clk,
    input  logic                  tx_rst,
    input  logic [CHANNELS*8-1:0] s_axis_tdata,
    input  logic [CHANNELS-1:0]   s_axis_tvalid,
    output logic [CHANNELS-1:0]   s_axis_tready,
    input  logic [CHANNELS-1:0]   s_axis_tlast,
    input  logic [CHANNELS-1:0]   s_axis_tuser,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic [CHANNELS-1:0]   cfg_ch_enable,
    output logic [CHANNELS-1:0]   stat_frame_done,
    output logic [CH_W-1:0]       stat_cur_ch,
    output logic                  busy
);

    localparam bit IS_PRIO = (ARB_MODE == "PRIO");

`ifdef ETH_TX_MQ_LEN_LIMIT_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_XFER = 2'd1, ST_DROP = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_XFER = 2'd1} state_t;
`endif

    state_t              state_r, state_next_s;
    logic [CH_W-1:0]     grant_r, grant_next_s;
    logic [CH_W-1:0]     rr_ptr_r, rr_ptr_next_s;
    logic [CH_W-1:0]     winner_s;
    logic [CHANNELS-1:0] req_s;
    logic                found_s;
    int                  rr_idx_s;
    logic                frame_start_s;

    logic                beat_ready_s;
    logic                accept_s;
    logic                xfer_accept_s;
    logic [7:0]          in_data_s;
    logic                in_valid_s;
    logic                in_last_s;
    logic                in_user_s;
    logic                trunc_s;
    logic                out_last_s;
    logic                out_user_s;

    logic [7:0]          m_tdata_r;
    logic                m_tvalid_r;
    logic                m_tlast_r;
    logic                m_tuser_r;
    logic [CH_W-1:0]     out_ch_r;
    logic [CHANNELS-1:0] frame_done_r;

    assign req_s      = s_axis_tvalid & cfg_ch_enable;
    assign in_data_s  = s_axis_tdata[{grant_r, 3'b000} +: 8];
    assign in_valid_s = s_axis_tvalid[grant_r];
    assign in_last_s  = s_axis_tlast[grant_r];
    assign in_user_s  = s_axis_tuser[grant_r];

    // Arbiter: RR scans upward from the pointer with wrap, PRIO takes lowest index
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
        rr_idx_s = 0;
        if (IS_PRIO) begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                winner_s = req_s[i] ? CH_W'(i) : winner_s;
            end
        end else begin
            for (int i = 1; i <= CHANNELS; i++) begin
                rr_idx_s = (int'(rr_ptr_r) + i) % CHANNELS;
                winner_s = (!found_s && req_s[rr_idx_s]) ? CH_W'(rr_idx_s) : winner_s;
                found_s  = found_s | req_s[rr_idx_s];
            end
        end
    end

    // Per-channel ready: only the granted channel may move, and only while a beat can land
    always_comb begin
        s_axis_tready = '0;
        beat_ready_s  = 1'b0;
        case (state_r)
            ST_XFER: beat_ready_s = m_axis_tready | ~m_tvalid_r;
`ifdef ETH_TX_MQ_LEN_LIMIT_EN
            ST_DROP: beat_ready_s = 1'b1;
`endif
            default: beat_ready_s = 1'b0;
        endcase
        s_axis_tready[grant_r] = beat_ready_s;
    end

    assign accept_s      = in_valid_s & beat_ready_s;
    assign xfer_accept_s = accept_s & (state_r == ST_XFER);

`ifdef ETH_TX_MQ_LEN_LIMIT_EN
    localparam int LEN_W = $clog2(MAX_FRAME_LEN + 1);

    logic [LEN_W-1:0] byte_cnt_r;
    logic [LEN_W-1:0] cnt_inc_s;

    assign cnt_inc_s = (byte_cnt_r == LEN_W'(MAX_FRAME_LEN)) ? byte_cnt_r : byte_cnt_r + LEN_W'(1);
    // The beat that reaches the cap without tlast is forced to end the frame as bad
    assign trunc_s   = xfer_accept_s & ~in_last_s & (cnt_inc_s == LEN_W'(MAX_FRAME_LEN));

    // Saturating byte counter, restarted at every grant
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            byte_cnt_r <= '0;
        end else if (frame_start_s) begin
            byte_cnt_r <= '0;
        end else if (xfer_accept_s) begin
            byte_cnt_r <= cnt_inc_s;
        end else begin
            byte_cnt_r <= byte_cnt_r;
        end
    end
`else
    assign trunc_s = 1'b0;
`endif

    assign out_last_s = in_last_s | trunc_s;
    assign out_user_s = in_user_s | trunc_s;

    // Next-state: one arbitration cycle per frame, grant held until the input tlast
    always_comb begin
        state_next_s  = state_r;
        grant_next_s  = grant_r;
        rr_ptr_next_s = rr_ptr_r;
        frame_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req_s) begin
                    state_next_s  = ST_XFER;
                    grant_next_s  = winner_s;
                    rr_ptr_next_s = IS_PRIO ? rr_ptr_r : winner_s;
                    frame_start_s = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (xfer_accept_s && in_last_s) begin
                    state_next_s = ST_IDLE;
`ifdef ETH_TX_MQ_LEN_LIMIT_EN
                end else if (trunc_s) begin
                    state_next_s = ST_DROP;
`endif
                end else begin
                    state_next_s = ST_XFER;
                end
            end
`ifdef ETH_TX_MQ_LEN_LIMIT_EN
            ST_DROP: begin
                if (accept_s && in_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DROP;
                end
            end
`endif
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM, grant and round-robin pointer registers
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state_r  <= ST_IDLE;
            grant_r  <= '0;
            rr_ptr_r <= CH_W'(CHANNELS - 1);
        end else begin
            state_r  <= state_next_s;
            grant_r  <= grant_next_s;
            rr_ptr_r <= rr_ptr_next_s;
        end
    end

    // Output register; holds its contents while the MAC stalls
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            m_tdata_r  <= 8'h00;
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
            m_tuser_r  <= 1'b0;
            out_ch_r   <= '0;
        end else if (xfer_accept_s) begin
            m_tdata_r  <= in_data_s;
            m_tvalid_r <= 1'b1;
            m_tlast_r  <= out_last_s;
            m_tuser_r  <= out_user_s;
            out_ch_r   <= grant_r;
        end else if (m_axis_tready) begin
            m_tvalid_r <= 1'b0;
        end else begin
            m_tvalid_r <= m_tvalid_r;
        end
    end

    // Frame-done pulse tagged with the channel of the beat that left, not the current grant
    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            frame_done_r <= '0;
        end else begin
            frame_done_r <= '0;
            if (m_tvalid_r && m_axis_tready && m_tlast_r) begin
                frame_done_r[out_ch_r] <= 1'b1;
            end
        end
    end

    assign m_axis_tdata    = m_tdata_r;
    assign m_axis_tvalid   = m_tvalid_r;
    assign m_axis_tlast    = m_tlast_r;
    assign m_axis_tuser    = m_tuser_r;
    assign stat_frame_done = frame_done_r;
    assign stat_cur_ch     = grant_r;
    assign busy            = (state_r != ST_IDLE) | m_tvalid_r;

endmodule

// File: tb/tb_eth_tx_mq_sched.sv
// Scoreboard bench for eth_tx_mq_sched: one RR instance and one PRIO instance.
module tb_eth_tx_mq_sched;

    localparam int CH    = 4;
    localparam int LIMIT = 64;

    logic         tx_clk = 1'b0;
    logic         tx_rst = 1'b1;
    logic [31:0]  s_tdata = 32'h0;
    logic [3:0]   tv_src = 4'h0, s_tlast = 4'h0, s_tuser = 4'h0, cfg_en = 4'hF;
    logic         m_tready = 1'b1;
    logic         sel_prio = 1'b0;
    logic [3:0]   rr_tvalid, pr_tvalid;

    logic [3:0] rr_tready, pr_tready, rr_fd, pr_fd;
    logic [7:0] rr_mdata, pr_mdata;
    logic       rr_mvalid, pr_mvalid, rr_mlast, pr_mlast, rr_muser, pr_muser, rr_busy, pr_busy;
    logic [1:0] rr_cur, pr_cur;

    logic [3:0] sel_tready, sel_fd;
    logic [7:0] sel_mdata;
    logic       sel_mvalid, sel_mlast, sel_muser, sel_busy;
    logic [1:0] sel_cur;

    assign rr_tvalid  = sel_prio ? 4'h0 : tv_src;
    assign pr_tvalid  = sel_prio ? tv_src : 4'h0;
    assign sel_tready = sel_prio ? pr_tready : rr_tready;
    assign sel_fd     = sel_prio ? pr_fd : rr_fd;
    assign sel_mdata  = sel_prio ? pr_mdata : rr_mdata;
    assign sel_mvalid = sel_prio ? pr_mvalid : rr_mvalid;
    assign sel_mlast  = sel_prio ? pr_mlast : rr_mlast;
    assign sel_muser  = sel_prio ? pr_muser : rr_muser;
    assign sel_busy   = sel_prio ? pr_busy : rr_busy;
    assign sel_cur    = sel_prio ? pr_cur : rr_cur;

    eth_tx_mq_sched #(.CHANNELS(CH), .ARB_MODE("RR"), .MAX_FRAME_LEN(LIMIT)) u_rr (
        .tx_clk(tx_clk), .tx_rst(tx_rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(rr_tvalid), .s_axis_tready(rr_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(rr_mdata), .m_axis_tvalid(rr_mvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(rr_mlast), .m_axis_tuser(rr_muser),
        .cfg_ch_enable(cfg_en), .stat_frame_done(rr_fd), .stat_cur_ch(rr_cur), .busy(rr_busy)
    );

    eth_tx_mq_sched #(.CHANNELS(CH), .ARB_MODE("PRIO"), .MAX_FRAME_LEN(LIMIT)) u_prio (
        .tx_clk(tx_clk), .tx_rst(tx_rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(pr_tvalid), .s_axis_tready(pr_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(pr_mdata), .m_axis_tvalid(pr_mvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(pr_mlast), .m_axis_tuser(pr_muser),
        .cfg_ch_enable(cfg_en), .stat_frame_done(pr_fd), .stat_cur_ch(pr_cur), .busy(pr_busy)
    );

    initial forever #5 tx_clk = ~tx_clk;

    // Source frames per channel: {user, last, data}
    logic [9:0]  src_mem [CH][256];
    int          src_wr [CH];
    int          src_rd [CH];
    // Scoreboard entries: {ch[1:0], user, last, data}
    logic [11:0] sb [$];
    int          out_cyc_q [$];

    int         n_cmp = 0, n_bad = 0, cyc = 0;
    logic       mon_en = 1'b1, fd_pending = 1'b0, prev_stall = 1'b0;
    logic [3:0] fd_exp = 4'h0, in_acc = 4'h0, rdy_pat = 4'hF;
    logic [9:0] prev_out = 10'h0;
    int         rdy_idx = 0;

    task automatic drive_inputs();
        logic [9:0] e;
        for (int c = 0; c < CH; c++) begin
            if (src_rd[c] < src_wr[c]) begin
                e = src_mem[c][src_rd[c]];
                tv_src[c] = 1'b1;
                s_tdata[c*8 +: 8] = e[7:0];
                s_tlast[c] = e[8];
                s_tuser[c] = e[9];
            end else begin
                tv_src[c] = 1'b0;
                s_tdata[c*8 +: 8] = 8'h00;
                s_tlast[c] = 1'b0;
                s_tuser[c] = 1'b0;
            end
        end
    endtask

    // Queue a frame on a source; optionally push what the MAC side should see
    task automatic push_frame(input int ch, input int len, input logic usr, input logic sb_en);
        logic [7:0] d;
        logic       lst, cut;
        for (int i = 0; i < len; i++) begin
            d   = 8'($urandom);
            lst = (i == len - 1);
            src_mem[ch][src_wr[ch]] = {usr, lst, d};
            src_wr[ch]++;
`ifdef ETH_TX_MQ_LEN_LIMIT_EN
            cut = (len > LIMIT) && (i == LIMIT - 1);
            if (sb_en && !((len > LIMIT) && (i >= LIMIT)))
                sb.push_back({2'(ch), usr | cut, lst | cut, d});
`else
            cut = 1'b0;
            if (sb_en) sb.push_back({2'(ch), usr | cut, lst | cut, d});
`endif
        end
        drive_inputs();
    endtask

    // One clock: monitor at negedge, advance sources after posedge
    task automatic cycle();
        logic [11:0] e;
        @(negedge tx_clk);
        cyc++;
        if (mon_en) begin
            n_cmp++;
            if (sel_fd !== (fd_pending ? fd_exp : 4'h0)) begin
                n_bad++;
                $display("FAIL frame_done: got %b expected %b (cycle %0d)", sel_fd, fd_pending ? fd_exp : 4'h0, cyc);
            end
            fd_pending = 1'b0;
            if (prev_stall) begin
                n_cmp++;
                if ({sel_mvalid, sel_muser, sel_mlast, sel_mdata} !== {1'b1, prev_out}) begin
                    n_bad++;
                    $display("FAIL stall_hold: got %b_%h expected 1_%h", sel_mvalid, {sel_muser, sel_mlast, sel_mdata}, prev_out);
                end
            end
            if (sel_mvalid && m_tready) begin
                out_cyc_q.push_back(cyc);
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_empty: got beat %h expected none", {sel_muser, sel_mlast, sel_mdata});
                end else begin
                    e = sb.pop_front();
                    if ({sel_muser, sel_mlast, sel_mdata} !== e[9:0]) begin
                        n_bad++;
                        $display("FAIL out_beat: got %h expected %h (ch %0d)", {sel_muser, sel_mlast, sel_mdata}, e[9:0], e[11:10]);
                    end
                    if (sel_mlast) begin
                        fd_pending = 1'b1;
                        fd_exp = 4'h1 << e[11:10];
                    end
                end
            end
        end
        prev_stall = sel_mvalid & ~m_tready;
        prev_out   = {sel_muser, sel_mlast, sel_mdata};
        in_acc     = tv_src & sel_tready;
        @(posedge tx_clk);
        #1;
        for (int c = 0; c < CH; c++) if (in_acc[c]) src_rd[c]++;
        m_tready = rdy_pat[rdy_idx];
        rdy_idx  = (rdy_idx + 1) % 4;
        drive_inputs();
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((sb.size() != 0 || sel_busy || fd_pending) && n < budget) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d cycles expected < %0d (sb %0d left)", name, n, budget, sb.size());
        end
    endtask

    task automatic do_reset();
        tx_rst = 1'b1;
        sb.delete();
        out_cyc_q.delete();
        for (int c = 0; c < CH; c++) begin
            src_wr[c] = 0;
            src_rd[c] = 0;
        end
        fd_pending = 1'b0;
        prev_stall = 1'b0;
        rdy_pat = 4'hF;
        rdy_idx = 0;
        m_tready = 1'b1;
        cfg_en = 4'hF;
        drive_inputs();
        repeat (2) @(posedge tx_clk);
        #1;
        tx_rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tx_rst = 1'b1;
        @(negedge tx_clk);
        n_cmp++;
        if ({rr_mvalid, rr_mlast, rr_muser, rr_mdata, rr_tready, rr_fd, rr_cur, rr_busy} !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 000000",
                     {rr_mvalid, rr_mlast, rr_muser, rr_mdata, rr_tready, rr_fd, rr_cur, rr_busy});
        end
        @(posedge tx_clk);
        #1;
        tx_rst = 1'b0;
        repeat (3) cycle();
        n_cmp++;
        if ({rr_mvalid, rr_tready, rr_busy, pr_mvalid, pr_busy} !== 8'h0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %h expected 00", {rr_mvalid, rr_tready, rr_busy, pr_mvalid, pr_busy});
        end
    endtask

    task automatic test_rr();
        do_reset();
        push_frame(0, 3, 1'b0, 1'b1);
        push_frame(1, 3, 1'b0, 1'b1);
        push_frame(2, 3, 1'b0, 1'b1);
        push_frame(3, 3, 1'b1, 1'b1);
        push_frame(0, 3, 1'b0, 1'b1);
        wait_drain(200, "rr");
        n_cmp++;
        if (out_cyc_q.size() != 15) begin
            n_bad++;
            $display("FAIL rr_beats: got %0d expected 15", out_cyc_q.size());
        end else begin
            for (int k = 1; k < 15; k++) begin
                n_cmp++;
                if (out_cyc_q[k] - out_cyc_q[k-1] != ((k % 3 == 0) ? 2 : 1)) begin
                    n_bad++;
                    $display("FAIL rr_spacing: got %0d expected %0d at beat %0d",
                             out_cyc_q[k] - out_cyc_q[k-1], (k % 3 == 0) ? 2 : 1, k);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        rdy_pat = 4'b1001;
        push_frame(0, 60, 1'b0, 1'b1);
        push_frame(1, 4, 1'b0, 1'b1);
        wait_drain(400, "bp");
        n_cmp++;
        if (out_cyc_q.size() != 64) begin
            n_bad++;
            $display("FAIL bp_beats: got %0d expected 64", out_cyc_q.size());
        end
        rdy_pat = 4'hF;
    endtask

    task automatic test_enable();
        int n = 0;
        do_reset();
        cfg_en = 4'b0100;
        push_frame(2, 20, 1'b0, 1'b1);
        push_frame(0, 5, 1'b0, 1'b1);
        push_frame(2, 5, 1'b0, 1'b0);
        while (src_rd[2] < 10 && n < 100) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (n >= 100) begin
            n_bad++;
            $display("FAIL en_start_timeout: got %0d beats expected 10", src_rd[2]);
        end
        cfg_en = 4'b0001;
        wait_drain(200, "en");
        repeat (10) cycle();
        n_cmp++;
        if (src_rd[2] != 20) begin
            n_bad++;
            $display("FAIL en_no_regrant: got %0d ch2 beats consumed expected 20", src_rd[2]);
        end
        n_cmp++;
        if (sel_cur !== 2'd0) begin
            n_bad++;
            $display("FAIL en_cur_ch: got %0d expected 0", sel_cur);
        end
    endtask

    task automatic test_long_frame();
        do_reset();
        push_frame(1, 100, 1'b0, 1'b1);
        push_frame(1, 3, 1'b0, 1'b1);
        wait_drain(500, "long");
        n_cmp++;
        if (src_rd[1] != 103) begin
            n_bad++;
            $display("FAIL long_consumed: got %0d expected 103", src_rd[1]);
        end
        n_cmp++;
`ifdef ETH_TX_MQ_LEN_LIMIT_EN
        if (out_cyc_q.size() != LIMIT + 3) begin
            n_bad++;
            $display("FAIL long_beats: got %0d expected %0d", out_cyc_q.size(), LIMIT + 3);
        end
`else
        if (out_cyc_q.size() != 103) begin
            n_bad++;
            $display("FAIL long_beats: got %0d expected 103", out_cyc_q.size());
        end
`endif
    endtask

    task automatic test_prio();
        do_reset();
        sel_prio = 1'b1;
        for (int f = 0; f < 3; f++) push_frame(1, 4, 1'b0, 1'b1);
        for (int f = 0; f < 2; f++) push_frame(3, 3, 1'b0, 1'b1);
        wait_drain(300, "prio");
        n_cmp++;
        if (out_cyc_q.size() != 18) begin
            n_bad++;
            $display("FAIL prio_beats: got %0d expected 18", out_cyc_q.size());
        end
        n_cmp++;
        if (pr_cur !== 2'd3) begin
            n_bad++;
            $display("FAIL prio_cur_ch: got %0d expected 3", pr_cur);
        end
        sel_prio = 1'b0;
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        do_reset();
        mon_en = 1'b0;
        push_frame(2, 20, 1'b0, 1'b0);
        while (src_rd[2] < 5 && n < 50) begin
            cycle();
            n++;
        end
        n_cmp++;
        if (n >= 50) begin
            n_bad++;
            $display("FAIL mid_start_timeout: got %0d beats expected 5", src_rd[2]);
        end
        tx_rst = 1'b1;
        #1;
        n_cmp++;
        if ({rr_mvalid, rr_mlast, rr_muser, rr_mdata, rr_tready, rr_fd, rr_cur, rr_busy} !== 24'h0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %h expected 000000",
                     {rr_mvalid, rr_mlast, rr_muser, rr_mdata, rr_tready, rr_fd, rr_cur, rr_busy});
        end
        for (int c = 0; c < CH; c++) begin
            src_wr[c] = 0;
            src_rd[c] = 0;
        end
        sb.delete();
        out_cyc_q.delete();
        drive_inputs();
        @(posedge tx_clk);
        #1;
        tx_rst = 1'b0;
        fd_pending = 1'b0;
        prev_stall = 1'b0;
        mon_en = 1'b1;
        push_frame(0, 3, 1'b0, 1'b1);
        push_frame(3, 3, 1'b0, 1'b1);
        wait_drain(100, "mid");
        n_cmp++;
        if (out_cyc_q.size() != 6) begin
            n_bad++;
            $display("FAIL mid_beats: got %0d expected 6", out_cyc_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_rr();
        test_back_pressure();
        test_enable();
        test_long_frame();
        test_prio();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
